// File: rtl/matrix_convolution_tile_pkg.sv
// Shared geometry, widths, FSM state and tag types for the 3x3 convolution tile engine.
package conv_pkg;

  localparam int unsigned TILE  = 6;
  localparam int unsigned KSZ   = 3;
  localparam int unsigned OSZ   = 4;
  localparam int unsigned LANES = 5;
  localparam int unsigned TAPS  = KSZ * KSZ;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 16;
  localparam int unsigned OPW   = 18;
  localparam int unsigned PW    = 37;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } conv_state_e;

  // Identifies which output a returning DSP product belongs to.
  typedef struct packed {
    logic       valid;
    logic [1:0] m;
    logic [1:0] n;
  } conv_tag_t;

  function automatic logic [OPW-1:0] sext_op(input logic [DW-1:0] x);
    return {{(OPW - DW){x[DW-1]}}, x};
  endfunction

endpackage

// File: rtl/matrix_convolution_tile_lane_sum.sv
// Sums the five DSP lane products, keeping only the low 16 bits (mod 2^16).
module conv_lane_sum
  import conv_pkg::*;
(
  input  logic [0:LANES-1][PW-1:0] lane_in,
  output logic [CW-1:0]            sum
);

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum = sum + CW'(lane_in[3'(k)]);
    end
  end

endmodule

// File: rtl/matrix_convolution_tile.sv
// 3x3 valid convolution of a 6x6 int8 tile: issues products to five external DSP lanes
// and accumulates their returned sums into a 4x4 array of 16-bit results.
module matrix_convolution_tile
  import conv_pkg::*;
#(
  parameter int unsigned DSP_LATENCY = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic signed [0:TILE-1][0:TILE-1][DW-1:0] input_tile,
  input  logic signed [0:KSZ-1][0:KSZ-1][DW-1:0]   kernel,
  output logic signed [0:OSZ-1][0:OSZ-1][CW-1:0]   c,
  output logic signed [0:LANES-1][OPW-1:0]       dsp_a0,
  output logic signed [0:LANES-1][OPW-1:0]       dsp_b0,
  input  logic signed [0:LANES-1][PW-1:0]        dsp_out,
  output logic                                   dsp_ce,
  output logic                                   done
);

  localparam int unsigned TAGW = $bits(conv_tag_t);

  conv_state_e state_q, state_d;
  logic        start_q;
  logic [4:0]  mul_cnt_q, mul_cnt_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic        ce_q, ce_d;
  logic        done_q, done_d;

  logic [0:TILE-1][0:TILE-1][DW-1:0] tile_q, tile_d;
  logic [0:KSZ-1][0:KSZ-1][DW-1:0]   kern_q, kern_d;
  logic [0:OSZ-1][0:OSZ-1][CW-1:0]   c_q, c_d;
  logic [0:LANES-1][OPW-1:0]         a_q, a_d, b_q, b_d;
  conv_tag_t [DSP_LATENCY-1:0]       tag_q, tag_d;

  logic [CW-1:0] lane_sum;
  logic          start_edge;
  logic [1:0]    out_m, out_n;
  logic          half;
  conv_tag_t     tag_new, tag_old;
  int unsigned   tap;
  logic [2:0]    row, col;

  assign start_edge = start & ~start_q;
  assign out_m      = mul_cnt_q[4:3];
  assign out_n      = mul_cnt_q[2:1];
  assign half       = mul_cnt_q[0];
  assign tag_old    = tag_q[DSP_LATENCY-1];

  conv_lane_sum u_lane_sum (
    .lane_in (dsp_out),
    .sum     (lane_sum)
  );

  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tile_d      = tile_q;
    kern_d      = kern_q;
    c_d         = c_q;
    done_d      = done_q;
    ce_d        = 1'b0;
    a_d         = '0;
    b_d         = '0;
    tag_new     = '0;
    tap         = 0;
    row         = '0;
    col         = '0;

    // Products return DSP_LATENCY edges after issue; the tag pipeline says where they go.
    if (tag_old.valid) begin
      c_d[tag_old.m][tag_old.n] = c_q[tag_old.m][tag_old.n] + lane_sum;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          tile_d    = input_tile;
          kern_d    = kernel;
          c_d       = '0;
          done_d    = 1'b0;
          mul_cnt_d = '0;
          state_d   = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        ce_d = 1'b1;
        for (int unsigned k = 0; k < LANES; k++) begin
          tap = half ? k + LANES : k;
          if (tap < TAPS) begin
            row = 3'(out_m) + 3'(tap / KSZ);
            col = 3'(out_n) + 3'(tap % KSZ);
            a_d[3'(k)] = sext_op(tile_q[row][col]);
            b_d[3'(k)] = sext_op(kern_q[2'(tap / KSZ)][2'(tap % KSZ)]);
          end
        end
        tag_new   = '{valid: 1'b1, m: out_m, n: out_n};
        mul_cnt_d = mul_cnt_q + 5'd1;
        if (mul_cnt_q == 5'd31) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 8'(DSP_LATENCY)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ce_d        = 1'b1;
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shift toward the oldest slot; the width cast drops the consumed tag.
    tag_d = (DSP_LATENCY * TAGW)'({tag_q, tag_new});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      mul_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ce_q        <= 1'b0;
      done_q      <= 1'b0;
      tile_q      <= '0;
      kern_q      <= '0;
      c_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      mul_cnt_q   <= mul_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ce_q        <= ce_d;
      done_q      <= done_d;
      tile_q      <= tile_d;
      kern_q      <= kern_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
    end
  end

  assign c      = c_q;
  assign dsp_a0 = a_q;
  assign dsp_b0 = b_q;
  assign dsp_ce = ce_q;
  assign done   = done_q;

endmodule

// File: tb/tb_matrix_convolution_tile.sv
// Directed and randomised checks of matrix_convolution_tile against a behavioural DSP model.
module tb_matrix_convolution_tile;

  typedef logic [0:5][0:5][7:0]  tile_t;
  typedef logic [0:2][0:2][7:0]  kern_t;
  typedef logic [0:3][0:3][15:0] res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  tile_t       tile;
  kern_t       kern;
  res_t        c;
  logic [0:4][17:0] dsp_a0, dsp_b0;
  logic [0:4][36:0] dsp_out;
  logic        dsp_ce;
  logic        done;

  int n_cmp;
  int n_bad;

  matrix_convolution_tile #(.DSP_LATENCY(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .input_tile (tile),
    .kernel     (kern),
    .c          (c),
    .dsp_a0     (dsp_a0),
    .dsp_b0     (dsp_b0),
    .dsp_out    (dsp_out),
    .dsp_ce     (dsp_ce),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] mul37(input logic signed [17:0] a, input logic signed [17:0] b);
    logic signed [36:0] p;
    p = a * b;
    return p;
  endfunction

  // Latency-2 DSP: operands visible after edge E, product visible after edge E+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_out <= '0;
    end else if (dsp_ce) begin
      for (int k = 0; k < 5; k++) dsp_out[k] <= mul37(dsp_a0[k], dsp_b0[k]);
    end
  end

  function automatic res_t ref_model(input tile_t t, input kern_t k);
    res_t r;
    logic [15:0] acc;
    int p;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int m = 0; m < 3; m++) begin
          for (int n = 0; n < 3; n++) begin
            p = int'($signed(t[i+m][j+n])) * int'($signed(k[m][n]));
            acc = acc + p[15:0];
          end
        end
        r[i][j] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_c(input string tag, input res_t exp);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), 32'(c[i][j]), 32'(exp[i][j]));
  endtask

  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts a run and returns the number of edges from the start edge to done (-1 on timeout).
  task automatic run(input int hold, input int reassert_at, output int lat,
                     output logic ce0, output logic ce1);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    lat = -1;
    ce0 = 1'bx;
    ce1 = 1'bx;
    while (cyc < 200 && lat < 0) begin
      @(negedge clk);
      if (cyc == 0) ce0 = dsp_ce;
      if (cyc == 1) ce1 = dsp_ce;
      if (done) lat = cyc;
      start = (cyc + 1 < hold) ||
              (reassert_at >= 0 && cyc >= reassert_at && cyc < reassert_at + 2);
      if (cyc == reassert_at) tile = {36{8'sd7}};
      if (lat < 0) begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int lat, input logic ce0, input logic ce1);
    chk({tag, "_latency"}, 32'(lat), 32'd35);
    chk({tag, "_ce_at_start"}, 32'(ce0), 32'd0);
    chk({tag, "_ce_running"}, 32'(ce1), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ce_after_done"}, 32'(dsp_ce), 32'd0);
  endtask

  initial begin
    int   lat;
    logic ce0, ce1;
    res_t exp;
    tile_t saved_tile;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    tile  = '0;
    kern  = '0;

    repeat (3) @(negedge clk);
    exp = '0;
    check_c("reset", exp);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ce", 32'(dsp_ce), 32'd0);
    chk("reset_a0_any", 32'(|dsp_a0), 32'd0);
    chk("reset_b0_any", 32'(|dsp_b0), 32'd0);
    rst_n = 1'b1;

    // All ones: every output sums nine 1*1 products.
    tile = {36{8'sd1}};
    kern = {9{8'sd1}};
    run(1, -1, lat, ce0, ce1);
    check_run("ones", lat, ce0, ce1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp[i][j] = 16'd9;
    check_c("ones", exp);
    repeat (3) @(negedge clk);
    chk("ones_done_sticky", 32'(done), 32'd1);
    chk("ones_c33_held", 32'(c[3][3]), 32'd9);
    reset_pulse(4);

    // Ramp tile with centre-only kernel picks out the interior pixel.
    for (int r = 0; r < 6; r++) for (int k = 0; k < 6; k++) tile[r][k] = 8'(r * 6 + k);
    kern = '0;
    kern[1][1] = 8'sd1;
    saved_tile = tile;
    run(1, -1, lat, ce0, ce1);
    check_run("ramp", lat, ce0, ce1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp[i][j] = 16'((i + 1) * 6 + (j + 1));
    check_c("ramp", exp);
    reset_pulse(4);

    // All -128: 9 * 16384 = 147456 wraps to 16384.
    tile = {36{8'h80}};
    kern = {9{8'h80}};
    run(1, -1, lat, ce0, ce1);
    check_run("neg", lat, ce0, ce1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp[i][j] = 16'd16384;
    check_c("neg", exp);
    reset_pulse(4);

    // Start held, re-pulsed mid-run, tile altered after latching: single unaffected run.
    tile = {36{8'sd1}};
    kern = {9{8'sd1}};
    run(4, 10, lat, ce0, ce1);
    check_run("hold", lat, ce0, ce1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp[i][j] = 16'd9;
    check_c("hold", exp);
    repeat (40) @(negedge clk);
    chk("hold_no_restart_done", 32'(done), 32'd1);
    chk("hold_no_restart_ce", 32'(dsp_ce), 32'd0);
    reset_pulse(4);

    // Reset in the middle of COMPUTE aborts to reset values.
    tile = {36{8'sd3}};
    kern = {9{8'sd2}};
    @(negedge clk);
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    exp = '0;
    check_c("abort", exp);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ce", 32'(dsp_ce), 32'd0);
    chk("abort_a0_any", 32'(|dsp_a0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tile = saved_tile;
    kern = '0;
    kern[1][1] = 8'sd1;
    run(1, -1, lat, ce0, ce1);
    check_run("after_abort", lat, ce0, ce1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp[i][j] = 16'((i + 1) * 6 + (j + 1));
    check_c("after_abort", exp);
    reset_pulse(4);

    // Random tiles and kernels against the wrapped reference model.
    for (int t = 0; t < 1000; t++) begin
      for (int r = 0; r < 6; r++) for (int k = 0; k < 6; k++) tile[r][k] = 8'($urandom);
      for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++) kern[r][k] = 8'($urandom);
      exp = ref_model(tile, kern);
      run(1, -1, lat, ce0, ce1);
      chk($sformatf("rand%0d_latency", t), 32'(lat), 32'd35);
      check_c($sformatf("rand%0d", t), exp);
      reset_pulse(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
